// File: rtl/nios_multi_timer_pkg.sv
// Shared definitions for the multi-channel interval timer.
// Holds the per-channel register offsets, the CONTROL/STATUS bit positions
// and the helpers that split a word address into channel and register fields.
package nios_multi_timer_pkg;

  // Register offsets within one channel's 8-word window.
  typedef enum logic [2:0] {
    REG_STATUS   = 3'd0,
    REG_CONTROL  = 3'd1,
    REG_PERIOD   = 3'd2,
    REG_SNAPSHOT = 3'd3,
    REG_PRESCALE = 3'd4
  } reg_off_e;

  // STATUS bits
  localparam int STATUS_TO  = 0;
  localparam int STATUS_RUN = 1;

  // CONTROL bits (START/STOP are write-only strobes)
  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  // Low three address bits select the register.
  function automatic logic [2:0] addr_reg(input logic [31:0] addr);
    return addr[2:0];
  endfunction

  // Remaining upper bits select the channel.
  function automatic int unsigned addr_chan(input logic [31:0] addr);
    return 32'(addr[31:3]);
  endfunction

endpackage

// File: rtl/nios_multi_timer_if.sv
// Avalon-MM slave bus plus interrupt outputs of the multi-channel timer.
//   address    : word address, upper bits channel, low 3 bits register
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data
//   readdata   : registered read data (1-cycle latency)
//   irq_ch     : per-channel interrupt
//   irq        : OR of irq_ch
interface nios_multi_timer_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 3 + $clog2(NUM_CH)
);
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [NUM_CH-1:0] irq_ch;
  logic              irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq_ch, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq_ch, irq
  );
endinterface

// File: rtl/nios_timer_channel.sv
// One timer channel: down-counter, prescaler, RUN/TO flags and the channel's
// CONTROL, PERIOD, SNAPSHOT and PRESCALE registers.
//   clk, reset_n : clock, asynchronous active-low reset
//   wr_en        : a bus write addressed to this channel
//   reg_sel      : register offset of that write
//   wdata        : write data
//   run, to      : STATUS flags
//   cont, ito    : stored CONTROL bits
//   period, snapshot, prescale : register contents for read-back
//   irq          : TO AND ITO
module nios_timer_channel
  import nios_multi_timer_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int PERIOD_RST = 49999,
  parameter int PRE_W      = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [2:0]       reg_sel,
  input  logic [31:0]      wdata,
  output logic             run,
  output logic             to,
  output logic             cont,
  output logic             ito,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] snapshot,
  output logic [PRE_W-1:0] prescale,
  output logic             irq
);

  localparam logic [CNT_W-1:0] PERIOD_INIT = CNT_W'(PERIOD_RST);

  logic [CNT_W-1:0] count;
  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic             timeout;
  logic             wr_status, wr_control, wr_period, wr_snapshot, wr_prescale;
  logic             start, stop;

  // '>=' keeps the prescaler from running past a PRESCALE that was lowered
  // while it was counting.
  assign tick    = run && (pre_cnt >= prescale);
  assign timeout = tick && (count == '0);

  assign wr_status   = wr_en && (reg_sel == REG_STATUS);
  assign wr_control  = wr_en && (reg_sel == REG_CONTROL);
  assign wr_period   = wr_en && (reg_sel == REG_PERIOD);
  assign wr_snapshot = wr_en && (reg_sel == REG_SNAPSHOT);
  assign wr_prescale = wr_en && (reg_sel == REG_PRESCALE);
  assign start       = wr_control && wdata[CTRL_START];
  assign stop        = wr_control && wdata[CTRL_STOP];

  assign irq = to & ito;

  // NOTE: sequential state uses non-blocking assignments only; later
  // statements in this block deliberately override earlier ones, which is
  // how the priorities below are expressed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count    <= PERIOD_INIT;
      period   <= PERIOD_INIT;
      snapshot <= '0;
      prescale <= '0;
      pre_cnt  <= '0;
      run      <= 1'b0;
      to       <= 1'b0;
      cont     <= 1'b0;
      ito      <= 1'b0;
    end else begin
      if (tick) begin
        pre_cnt <= '0;
      end else if (run) begin
        pre_cnt <= pre_cnt + PRE_W'(1);
      end

      if (tick) begin
        if (count == '0) begin
          count <= period;
          if (!cont) run <= 1'b0;
        end else begin
          count <= count - CNT_W'(1);
        end
      end

      // Clear first so a timeout on the same edge is not lost.
      if (wr_status) to <= 1'b0;
      if (timeout)   to <= 1'b1;

      if (wr_control) begin
        cont <= wdata[CTRL_CONT];
        ito  <= wdata[CTRL_ITO];
      end

      // START after STOP so a write carrying both leaves the timer running.
      if (stop) run <= 1'b0;
      if (start) begin
        run     <= 1'b1;
        pre_cnt <= '0;
      end

      if (wr_period) begin
        period  <= wdata[CNT_W-1:0];
        count   <= wdata[CNT_W-1:0];
        pre_cnt <= '0;
        run     <= 1'b0;
      end

      if (wr_prescale) prescale <= wdata[PRE_W-1:0];
      if (wr_snapshot) snapshot <= count;
    end
  end

endmodule

// File: rtl/nios_multi_timer.sv
// Multi-channel interval timer with an Avalon-MM slave register interface.
// The top level only decodes the address, fans the write strobe out to the
// addressed channel, multiplexes read data and ORs the channel interrupts.
//   clk     : clock
//   reset_n : asynchronous active-low reset
//   bus     : Avalon-MM slave port plus irq_ch / irq (nios_multi_timer_if)
module nios_multi_timer
  import nios_multi_timer_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 32,
  parameter int PERIOD_RST = 49999,
  parameter int PRE_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  nios_multi_timer_if.slave    bus
);

  logic [2:0]                   reg_sel;
  int unsigned                  chan_sel;
  logic                         wr;
  logic [NUM_CH-1:0]            wr_en;
  logic [NUM_CH-1:0]            run, to, cont, ito, irq_ch;
  logic [NUM_CH-1:0][CNT_W-1:0] period, snapshot;
  logic [NUM_CH-1:0][PRE_W-1:0] prescale;
  logic [31:0]                  rd_next;

  assign reg_sel  = addr_reg(32'(bus.address));
  assign chan_sel = addr_chan(32'(bus.address));
  assign wr       = bus.chipselect && !bus.write_n;

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path can infer a latch.
  always_comb begin
    wr_en = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_en[i] = wr && (chan_sel == unsigned'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    nios_timer_channel #(
      .CNT_W      (CNT_W),
      .PERIOD_RST (PERIOD_RST),
      .PRE_W      (PRE_W)
    ) u_channel (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr_en    (wr_en[g]),
      .reg_sel  (reg_sel),
      .wdata    (bus.writedata),
      .run      (run[g]),
      .to       (to[g]),
      .cont     (cont[g]),
      .ito      (ito[g]),
      .period   (period[g]),
      .snapshot (snapshot[g]),
      .prescale (prescale[g]),
      .irq      (irq_ch[g])
    );
  end

  // Channel numbers at or above NUM_CH match no channel and read as 0.
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (chan_sel == unsigned'(i)) begin
        case (reg_sel)
          REG_STATUS: begin
            rd_next[STATUS_RUN] = run[i];
            rd_next[STATUS_TO]  = to[i];
          end
          REG_CONTROL: begin
            rd_next[CTRL_CONT] = cont[i];
            rd_next[CTRL_ITO]  = ito[i];
          end
          REG_PERIOD:   rd_next = 32'(period[i]);
          REG_SNAPSHOT: rd_next = 32'(snapshot[i]);
          REG_PRESCALE: rd_next = 32'(prescale[i]);
          default:      rd_next = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= '0;
    end else begin
      bus.readdata <= rd_next;
    end
  end

  assign bus.irq_ch = irq_ch;
  assign bus.irq    = |irq_ch;

endmodule

// File: tb/tb_nios_multi_timer.sv
// Directed testbench for nios_multi_timer (NUM_CH=4, CNT_W=32,
// PERIOD_RST=49999, PRE_W=8). Inputs change and outputs are sampled on the
// falling clock edge; the DUT acts on the rising edge.
module tb_nios_multi_timer;
  import nios_multi_timer_pkg::*;

  localparam int NUM_CH = 4;

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;

  nios_multi_timer_if #(.NUM_CH(NUM_CH)) bus ();

  nios_multi_timer #(
    .NUM_CH     (NUM_CH),
    .CNT_W      (32),
    .PERIOD_RST (49999),
    .PRE_W      (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [4:0] ra(input int ch, input int r);
    return 5'(ch * 8 + r);
  endfunction

  // The write is captured on the rising edge between the two falling edges.
  task automatic bus_write(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.address    = addr;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = data;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [4:0] addr, output logic [31:0] data);
    @(negedge clk);
    bus.address    = addr;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    @(negedge clk);
    data           = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (bus.readdata !== 32'd0) begin miscompares++; $display("FAIL reset_readdata: got %h expected 0", bus.readdata); end
    vectors++; if (bus.irq_ch !== 4'd0 || bus.irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b/%b expected 0000/0", bus.irq_ch, bus.irq); end
    reset_n = 1'b1;
    bus_read(ra(0, REG_PERIOD), rd);
    vectors++; if (rd !== 32'd49999) begin miscompares++; $display("FAIL reset_period0: got %0d expected 49999", rd); end
    bus_read(ra(3, REG_PERIOD), rd);
    vectors++; if (rd !== 32'd49999) begin miscompares++; $display("FAIL reset_period3: got %0d expected 49999", rd); end
    bus_read(ra(1, REG_STATUS), rd);
    vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL reset_status1: got %h expected 0", rd); end
    bus_read(ra(2, REG_CONTROL), rd);
    vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL reset_control2: got %h expected 0", rd); end
    bus_read(ra(0, REG_PRESCALE), rd);
    vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL reset_prescale0: got %h expected 0", rd); end
    bus_read(ra(0, REG_SNAPSHOT), rd);
    vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL reset_snapshot0: got %h expected 0", rd); end
    bus_write(ra(1, REG_SNAPSHOT), 32'd0);
    bus_read(ra(1, REG_SNAPSHOT), rd);
    vectors++; if (rd !== 32'd49999) begin miscompares++; $display("FAIL reset_count1: got %0d expected 49999", rd); end
    bus_write(ra(2, 6), 32'hFFFF_FFFF);
    bus_read(ra(2, 6), rd);
    vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL unused_reg6: got %h expected 0", rd); end
    bus_read(ra(0, 5), rd);
    vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL unused_reg5: got %h expected 0", rd); end
  endtask

  // Ch0 period 9, prescale 0, continuous: TO every 10 clocks, sticky.
  task automatic test_continuous();
    logic exp;
    bus_write(ra(0, REG_PERIOD), 32'd9);
    bus_write(ra(0, REG_PRESCALE), 32'd0);
    bus_write(ra(0, REG_CONTROL), 32'h7);
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      exp = (k >= 10);
      vectors++; if (bus.irq_ch[0] !== exp || bus.irq !== exp) begin miscompares++; $display("FAIL cont_irq k=%0d: got %b/%b expected %b", k, bus.irq_ch[0], bus.irq, exp); end
    end
    bus_write(ra(0, REG_STATUS), 32'd0);
    vectors++; if (bus.irq_ch[0] !== 1'b0) begin miscompares++; $display("FAIL cont_clear: got %b expected 0", bus.irq_ch[0]); end
    for (int k = 28; k <= 30; k++) begin
      @(negedge clk);
      exp = (k == 30);
      vectors++; if (bus.irq_ch[0] !== exp) begin miscompares++; $display("FAIL cont_second k=%0d: got %b expected %b", k, bus.irq_ch[0], exp); end
    end
    bus_write(ra(0, REG_CONTROL), 32'h8);
    bus_write(ra(0, REG_STATUS), 32'd0);
    vectors++; if (bus.irq !== 1'b0) begin miscompares++; $display("FAIL cont_stop_irq: got %b expected 0", bus.irq); end
  endtask

  // Ch2 period 4, prescale 3, one-shot: single TO 20 clocks after START.
  task automatic test_one_shot();
    logic [31:0] rd;
    logic        exp;
    bus_write(ra(2, REG_PERIOD), 32'd4);
    bus_write(ra(2, REG_PRESCALE), 32'd3);
    bus_write(ra(2, REG_CONTROL), 32'h5);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      exp = (k >= 20);
      vectors++; if (bus.irq_ch[2] !== exp) begin miscompares++; $display("FAIL oneshot_irq k=%0d: got %b expected %b", k, bus.irq_ch[2], exp); end
    end
    bus_read(ra(2, REG_STATUS), rd);
    vectors++; if (rd !== 32'h1) begin miscompares++; $display("FAIL oneshot_status: got %h expected 1", rd); end
    bus_write(ra(2, REG_SNAPSHOT), 32'd0);
    bus_read(ra(2, REG_SNAPSHOT), rd);
    vectors++; if (rd !== 32'd4) begin miscompares++; $display("FAIL oneshot_snapshot: got %0d expected 4", rd); end
    bus_write(ra(2, REG_STATUS), 32'd0);
    bus_read(ra(2, REG_STATUS), rd);
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL oneshot_cleared: got %h expected 0", rd); end
  endtask

  // Ch1 period 4: STATUS write lands on the same edge as the 1st timeout.
  task automatic test_status_race();
    logic [31:0] rd;
    bus_write(ra(1, REG_PERIOD), 32'd4);
    bus_write(ra(1, REG_CONTROL), 32'h7);
    repeat (3) @(negedge clk);
    vectors++; if (bus.irq_ch[1] !== 1'b0) begin miscompares++; $display("FAIL race_before: got %b expected 0", bus.irq_ch[1]); end
    bus_write(ra(1, REG_STATUS), 32'd0);
    vectors++; if (bus.irq_ch[1] !== 1'b1 || bus.irq !== 1'b1) begin miscompares++; $display("FAIL race_irq: got %b/%b expected 1/1", bus.irq_ch[1], bus.irq); end
    bus_read(ra(1, REG_STATUS), rd);
    vectors++; if (rd !== 32'h3) begin miscompares++; $display("FAIL race_status: got %h expected 3", rd); end
    bus_write(ra(1, REG_CONTROL), 32'h8);
    bus_write(ra(1, REG_STATUS), 32'd0);
    vectors++; if (bus.irq !== 1'b0) begin miscompares++; $display("FAIL race_cleanup: got %b expected 0", bus.irq); end
  endtask

  // Ch3 running from reset value, PERIOD write reloads count and stops.
  task automatic test_period_reload();
    logic [31:0] rd;
    bus_write(ra(3, REG_CONTROL), 32'h4);
    repeat (5) @(negedge clk);
    bus_write(ra(3, REG_PERIOD), 32'd100);
    bus_read(ra(3, REG_STATUS), rd);
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL reload_status: got %h expected 0", rd); end
    bus_write(ra(3, REG_SNAPSHOT), 32'd0);
    bus_read(ra(3, REG_SNAPSHOT), rd);
    vectors++; if (rd !== 32'd100) begin miscompares++; $display("FAIL reload_snapshot: got %0d expected 100", rd); end
    bus_read(ra(3, REG_PERIOD), rd);
    vectors++; if (rd !== 32'd100) begin miscompares++; $display("FAIL reload_period: got %0d expected 100", rd); end
  endtask

  // Ch3 count 100: START+STOP runs, 4 ticks pass before STOP lands -> 96.
  task automatic test_start_stop();
    logic [31:0] rd;
    bus_write(ra(3, REG_CONTROL), 32'hC);
    bus_read(ra(3, REG_STATUS), rd);
    vectors++; if (rd !== 32'h2) begin miscompares++; $display("FAIL startstop_run: got %h expected 2", rd); end
    bus_write(ra(3, REG_CONTROL), 32'h8);
    bus_read(ra(3, REG_STATUS), rd);
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL startstop_stopped: got %h expected 0", rd); end
    bus_read(ra(3, REG_CONTROL), rd);
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL startstop_strobes: got %h expected 0", rd); end
    bus_write(ra(3, REG_SNAPSHOT), 32'd0);
    bus_read(ra(3, REG_SNAPSHOT), rd);
    vectors++; if (rd !== 32'd96) begin miscompares++; $display("FAIL startstop_count: got %0d expected 96", rd); end
    repeat (50) @(negedge clk);
    bus_write(ra(3, REG_SNAPSHOT), 32'd0);
    bus_read(ra(3, REG_SNAPSHOT), rd);
    vectors++; if (rd !== 32'd96) begin miscompares++; $display("FAIL startstop_frozen: got %0d expected 96", rd); end
  endtask

  // Ch0 period 5 started 2 clocks before ch1 period 3: both time out together.
  task automatic test_simultaneous();
    logic [3:0] exp;
    bus_write(ra(0, REG_PERIOD), 32'd5);
    bus_write(ra(1, REG_PERIOD), 32'd3);
    bus_write(ra(0, REG_CONTROL), 32'h5);
    bus_write(ra(1, REG_CONTROL), 32'h5);
    for (int k = 3; k <= 6; k++) begin
      @(negedge clk);
      exp = (k == 6) ? 4'b0011 : 4'b0000;
      vectors++; if (bus.irq_ch !== exp) begin miscompares++; $display("FAIL simul_irq k=%0d: got %b expected %b", k, bus.irq_ch, exp); end
    end
    vectors++; if (bus.irq !== 1'b1) begin miscompares++; $display("FAIL simul_or: got %b expected 1", bus.irq); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    bus_write(ra(2, REG_CONTROL), 32'h6);
    bus_write(ra(3, REG_CONTROL), 32'h4);
    repeat (7) @(negedge clk);
    vectors++; if (bus.irq !== 1'b1) begin miscompares++; $display("FAIL midrst_pre: got %b expected 1", bus.irq); end
    #2 reset_n = 1'b0;
    #1;
    vectors++; if (bus.irq !== 1'b0 || bus.irq_ch !== 4'd0) begin miscompares++; $display("FAIL midrst_irq: got %b/%b expected 0/0000", bus.irq, bus.irq_ch); end
    vectors++; if (bus.readdata !== 32'd0) begin miscompares++; $display("FAIL midrst_readdata: got %h expected 0", bus.readdata); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    vectors++; if (bus.irq !== 1'b0) begin miscompares++; $display("FAIL midrst_release: got %b expected 0", bus.irq); end
    bus_read(ra(0, REG_STATUS), rd);
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL midrst_status0: got %h expected 0", rd); end
    bus_read(ra(2, REG_STATUS), rd);
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL midrst_status2: got %h expected 0", rd); end
    bus_read(ra(1, REG_CONTROL), rd);
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL midrst_control1: got %h expected 0", rd); end
    bus_read(ra(2, REG_PERIOD), rd);
    vectors++; if (rd !== 32'd49999) begin miscompares++; $display("FAIL midrst_period2: got %0d expected 49999", rd); end
    bus_read(ra(2, REG_PRESCALE), rd);
    vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL midrst_prescale2: got %0d expected 0", rd); end
    bus_read(ra(3, REG_SNAPSHOT), rd);
    vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL midrst_snapshot3: got %0d expected 0", rd); end
    bus_write(ra(3, REG_SNAPSHOT), 32'd0);
    bus_read(ra(3, REG_SNAPSHOT), rd);
    vectors++; if (rd !== 32'd49999) begin miscompares++; $display("FAIL midrst_count3: got %0d expected 49999", rd); end
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    reset_n        = 1'b0;
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    test_reset();
    test_continuous();
    test_one_shot();
    test_status_race();
    test_period_reload();
    test_start_stop();
    test_simultaneous();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
